// File: rtl/decode_execute_pkg.sv
// Shared types and constants for the decode/execute pipeline register.
package decode_execute_pkg;

  localparam int unsigned CTRL_W = 16;

  typedef struct packed {
    logic       pc_src;
    logic       reg_write;
    logic       reg_write_v;
    logic       mem_to_reg;
    logic       mem_write;
    logic [2:0] alu_control;
    logic       alu_sel;
    logic       branch;
    logic       alu_src;
    logic       mem_src;
    logic [1:0] flag_write;
    logic [1:0] mem_data;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

  // pc_src, reg_write, reg_write_v, mem_write, branch, flag_write[1:0]
  localparam logic [CTRL_W-1:0] CTRL_SIDE_EFFECT_MASK = 16'hE84C;

  // Strip architectural side effects from a bundle that belongs to a bubble.
  function automatic id_ex_ctrl_t gate_ctrl(input id_ex_ctrl_t ctrl, input logic valid);
    logic [CTRL_W-1:0] raw;
    raw = ctrl;
    if (!valid) begin
      raw = raw & ~CTRL_SIDE_EFFECT_MASK;
    end
    return id_ex_ctrl_t'(raw);
  endfunction

endpackage

// File: rtl/decode_execute_register_pipe_reg.sv
// Width-parameterised register with load enable and synchronous clear.
module pipe_reg_en_clr #(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Clear beats enable so a flush still lands while stalled.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = CLR_VAL;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/decode_execute_register.sv
// Decode-to-execute pipeline register with stall, flush and a saturating bubble counter.
module decode_execute_register
  import decode_execute_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned VEC_WIDTH  = 256,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  valid_d,
  input  id_ex_ctrl_t           ctrl_d,
  input  logic [DATA_WIDTH-1:0] rd1_d,
  input  logic [DATA_WIDTH-1:0] rd2_d,
  input  logic [VEC_WIDTH-1:0]  rdv1_d,
  input  logic [VEC_WIDTH-1:0]  rdv2_d,
  input  logic [DATA_WIDTH-1:0] ext_imm_d,
  input  logic [REG_ADDR_W-1:0] ra1_d,
  input  logic [REG_ADDR_W-1:0] ra2_d,
  input  logic [REG_ADDR_W-1:0] wa3_d,
  output logic                  valid_e,
  output id_ex_ctrl_t           ctrl_e,
  output logic [DATA_WIDTH-1:0] rd1_e,
  output logic [DATA_WIDTH-1:0] rd2_e,
  output logic [VEC_WIDTH-1:0]  rdv1_e,
  output logic [VEC_WIDTH-1:0]  rdv2_e,
  output logic [DATA_WIDTH-1:0] ext_imm_e,
  output logic [REG_ADDR_W-1:0] ra1_e,
  output logic [REG_ADDR_W-1:0] ra2_e,
  output logic [REG_ADDR_W-1:0] wa3_e,
  output logic [CNT_W-1:0]      bubble_count
);

  localparam int unsigned CV_W   = CTRL_W + 1;
  localparam int unsigned SCL_W  = 3 * DATA_WIDTH;
  localparam int unsigned VEC2_W = 2 * VEC_WIDTH;
  localparam int unsigned ADR_W  = 3 * REG_ADDR_W;

  logic load_en;
  assign load_en = ~stall_e;

  id_ex_ctrl_t ctrl_gated;
  assign ctrl_gated = gate_ctrl(ctrl_d, valid_d);

  logic [CV_W-1:0]   cv_q;
  logic [SCL_W-1:0]  scl_q;
  logic [VEC2_W-1:0] vec_q;
  logic [ADR_W-1:0]  adr_q;

  pipe_reg_en_clr #(.W(CV_W), .CLR_VAL({CTRL_BUBBLE, 1'b0})) u_ctrl_reg (
    .clk(clk), .rst(rst), .en(load_en), .clr(flush_e),
    .d({ctrl_gated, valid_d}), .q(cv_q)
  );

  pipe_reg_en_clr #(.W(SCL_W)) u_scalar_reg (
    .clk(clk), .rst(rst), .en(load_en), .clr(flush_e),
    .d({rd1_d, rd2_d, ext_imm_d}), .q(scl_q)
  );

  pipe_reg_en_clr #(.W(VEC2_W)) u_vector_reg (
    .clk(clk), .rst(rst), .en(load_en), .clr(flush_e),
    .d({rdv1_d, rdv2_d}), .q(vec_q)
  );

  pipe_reg_en_clr #(.W(ADR_W)) u_addr_reg (
    .clk(clk), .rst(rst), .en(load_en), .clr(flush_e),
    .d({ra1_d, ra2_d, wa3_d}), .q(adr_q)
  );

  assign {ctrl_e, valid_e}          = cv_q;
  assign {rd1_e, rd2_e, ext_imm_e}  = scl_q;
  assign {rdv1_e, rdv2_e}           = vec_q;
  assign {ra1_e, ra2_e, wa3_e}      = adr_q;

  logic [CNT_W-1:0] bubble_count_q;
  logic [CNT_W-1:0] bubble_count_d;

  // Count every inserted bubble, pinning at all-ones instead of wrapping.
  always_comb begin
    bubble_count_d = bubble_count_q;
    if (flush_e && (bubble_count_q != '1)) begin
      bubble_count_d = bubble_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count_q <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_decode_execute_register.sv
// Directed bench for decode_execute_register, plus a 4-bit-counter instance for saturation.
module tb_decode_execute_register;
  import decode_execute_pkg::*;

  logic          clk = 1'b0;
  logic          rst, stall_e, flush_e, valid_d;
  id_ex_ctrl_t   ctrl_d;
  logic [31:0]   rd1_d, rd2_d, ext_imm_d;
  logic [255:0]  rdv1_d, rdv2_d;
  logic [4:0]    ra1_d, ra2_d, wa3_d;

  logic          valid_e;
  id_ex_ctrl_t   ctrl_e;
  logic [31:0]   rd1_e, rd2_e, ext_imm_e;
  logic [255:0]  rdv1_e, rdv2_e;
  logic [4:0]    ra1_e, ra2_e, wa3_e;
  logic [15:0]   bubble_count;

  logic          s_valid_e;
  id_ex_ctrl_t   s_ctrl_e;
  logic [31:0]   s_rd1_e, s_rd2_e, s_ext_imm_e;
  logic [255:0]  s_rdv1_e, s_rdv2_e;
  logic [4:0]    s_ra1_e, s_ra2_e, s_wa3_e;
  logic [3:0]    s_bubble_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_execute_register dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
    .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .rdv1_d(rdv1_d), .rdv2_d(rdv2_d),
    .ext_imm_d(ext_imm_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .valid_e(valid_e), .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .rdv1_e(rdv1_e), .rdv2_e(rdv2_e), .ext_imm_e(ext_imm_e),
    .ra1_e(ra1_e), .ra2_e(ra2_e), .wa3_e(wa3_e), .bubble_count(bubble_count)
  );

  decode_execute_register #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
    .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .rdv1_d(rdv1_d), .rdv2_d(rdv2_d),
    .ext_imm_d(ext_imm_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .valid_e(s_valid_e), .ctrl_e(s_ctrl_e), .rd1_e(s_rd1_e), .rd2_e(s_rd2_e),
    .rdv1_e(s_rdv1_e), .rdv2_e(s_rdv2_e), .ext_imm_e(s_ext_imm_e),
    .ra1_e(s_ra1_e), .ra2_e(s_ra2_e), .wa3_e(s_wa3_e), .bubble_count(s_bubble_count)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] vec_a;
    vec_a = {8'h01, {31{8'h0F}}};

    // Reset with random inputs, including random stall/flush
    rst       = 1'b1;
    stall_e   = 1'($urandom);
    flush_e   = 1'($urandom);
    valid_d   = 1'($urandom);
    ctrl_d    = id_ex_ctrl_t'(16'($urandom));
    rd1_d     = $urandom;
    rd2_d     = $urandom;
    ext_imm_d = $urandom;
    rdv1_d    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rdv2_d    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ra1_d     = 5'($urandom);
    ra2_d     = 5'($urandom);
    wa3_d     = 5'($urandom);
    step();
    step();
    check("rst_valid",   256'(valid_e), 256'(0));
    check("rst_ctrl",    256'(ctrl_e), 256'(0));
    check("rst_rd1",     256'(rd1_e), 256'(0));
    check("rst_rd2",     256'(rd2_e), 256'(0));
    check("rst_rdv1",    rdv1_e, 256'(0));
    check("rst_rdv2",    rdv2_e, 256'(0));
    check("rst_imm",     256'(ext_imm_e), 256'(0));
    check("rst_addr",    256'({ra1_e, ra2_e, wa3_e}), 256'(0));
    check("rst_bubble",  256'(bubble_count), 256'(0));
    check("rst_sbubble", 256'(s_bubble_count), 256'(0));

    // Plain load, one-cycle latency
    rst       = 1'b0;
    stall_e   = 1'b0;
    flush_e   = 1'b0;
    valid_d   = 1'b1;
    ctrl_d    = id_ex_ctrl_t'(16'hFFFF);
    rd1_d     = 32'hDEADBEEF;
    rd2_d     = 32'hCAFEF00D;
    ext_imm_d = 32'h0000_0ABC;
    rdv1_d    = vec_a;
    rdv2_d    = ~vec_a;
    ra1_d     = 5'd3;
    ra2_d     = 5'd30;
    wa3_d     = 5'd7;
    step();
    check("ld_valid", 256'(valid_e), 256'(1));
    check("ld_ctrl",  256'(ctrl_e), 256'(16'hFFFF));
    check("ld_rd1",   256'(rd1_e), 256'(32'hDEADBEEF));
    check("ld_rd2",   256'(rd2_e), 256'(32'hCAFEF00D));
    check("ld_imm",   256'(ext_imm_e), 256'(32'h0000_0ABC));
    check("ld_rdv1",  rdv1_e, vec_a);
    check("ld_rdv2",  rdv2_e, ~vec_a);
    check("ld_ra1",   256'(ra1_e), 256'(5'd3));
    check("ld_ra2",   256'(ra2_e), 256'(5'd30));
    check("ld_wa3",   256'(wa3_e), 256'(5'd7));
    check("ld_bubble", 256'(bubble_count), 256'(0));

    // Stall holds contents
    rd1_d  = 32'h11;
    ctrl_d = id_ex_ctrl_t'(16'h0123);
    step();
    check("st_pre_rd1", 256'(rd1_e), 256'(32'h11));
    stall_e = 1'b1;
    rd1_d   = 32'h22;
    ctrl_d  = id_ex_ctrl_t'(16'h4567);
    wa3_d   = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_rd1",  256'(rd1_e), 256'(32'h11));
      check("st_ctrl", 256'(ctrl_e), 256'(16'h0123));
      check("st_wa3",  256'(wa3_e), 256'(5'd7));
    end
    stall_e = 1'b0;
    step();
    check("st_rel_rd1",  256'(rd1_e), 256'(32'h22));
    check("st_rel_ctrl", 256'(ctrl_e), 256'(16'h4567));
    check("st_rel_wa3",  256'(wa3_e), 256'(5'd9));

    // Flush together with stall: flush wins
    stall_e = 1'b1;
    flush_e = 1'b1;
    step();
    check("fl_valid",   256'(valid_e), 256'(0));
    check("fl_ctrl",    256'(ctrl_e), 256'(0));
    check("fl_rd1",     256'(rd1_e), 256'(0));
    check("fl_rdv1",    rdv1_e, 256'(0));
    check("fl_wa3",     256'(wa3_e), 256'(0));
    check("fl_bubble",  256'(bubble_count), 256'(1));
    check("fl_sbubble", 256'(s_bubble_count), 256'(1));

    // valid_d=0 gates side-effecting control bits
    stall_e = 1'b0;
    flush_e = 1'b0;
    valid_d = 1'b0;
    ctrl_d  = id_ex_ctrl_t'(16'hFFFF);
    rd1_d   = 32'h5A5A_A5A5;
    step();
    check("gt_valid",     256'(valid_e), 256'(0));
    check("gt_ctrl",      256'(ctrl_e), 256'(16'h17B3));
    check("gt_reg_write", 256'(ctrl_e.reg_write), 256'(0));
    check("gt_mem_write", 256'(ctrl_e.mem_write), 256'(0));
    check("gt_branch",    256'(ctrl_e.branch), 256'(0));
    check("gt_pc_src",    256'(ctrl_e.pc_src), 256'(0));
    check("gt_flag_wr",   256'(ctrl_e.flag_write), 256'(0));
    check("gt_alu_ctl",   256'(ctrl_e.alu_control), 256'(3'b111));
    check("gt_rd1",       256'(rd1_e), 256'(32'h5A5A_A5A5));
    check("gt_bubble",    256'(bubble_count), 256'(1));

    // Stall alone holds the bubble counter
    stall_e = 1'b1;
    step();
    check("sth_bubble", 256'(bubble_count), 256'(1));

    // Back-to-back flushes: 4-bit counter saturates, 16-bit keeps counting
    stall_e = 1'b0;
    flush_e = 1'b1;
    valid_d = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 13) begin
        check("sat_pre",  256'(s_bubble_count), 256'(4'hE));
      end
      if (i == 14) begin
        check("sat_hit",  256'(s_bubble_count), 256'(4'hF));
      end
    end
    check("sat_hold",  256'(s_bubble_count), 256'(4'hF));
    check("sat_wide",  256'(bubble_count), 256'(16'd21));
    check("sat_valid", 256'(s_valid_e), 256'(0));

    // Reset during flush clears the counter
    rst = 1'b1;
    step();
    check("rfl_sbubble", 256'(s_bubble_count), 256'(0));
    check("rfl_bubble",  256'(bubble_count), 256'(0));

    // Reset during stall wins
    rst     = 1'b0;
    flush_e = 1'b0;
    valid_d = 1'b1;
    ctrl_d  = id_ex_ctrl_t'(16'h00F0);
    rd1_d   = 32'h77;
    step();
    check("rst2_pre_rd1", 256'(rd1_e), 256'(32'h77));
    stall_e = 1'b1;
    rst     = 1'b1;
    step();
    check("rst2_rd1",   256'(rd1_e), 256'(0));
    check("rst2_valid", 256'(valid_e), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
